// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter granting one producer at a time bursting words into a shared fifo.
// A burst ends on last, on reaching MAXBURST words, or when the owner drops req.
module fifo_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 32,
    parameter int MAXBURST = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         last,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         ack,
    input  logic                    fifo_full,
    output logic [WIDTH-1:0]        fifo_datain,
    output logic                    fifo_write,
    output logic [NREQ-1:0]         grant,
    output logic                    busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAXBURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_next;
    logic [NREQ-1:0] grant_next;
    logic [PW-1:0]   rr_ptr, rr_next;
    logic [CW-1:0]   beats, beats_next;
    logic [PW-1:0]   gidx, pick;
    logic            pick_vld;
    logic            done;

    // Index of the current owner; only meaningful while grant is non-zero.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) gidx = PW'(i);
    end

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_vld && req[(int'(rr_ptr) + k) % NREQ]) begin
                pick     = PW'((int'(rr_ptr) + k) % NREQ);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        fifo_datain = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) fifo_datain = fifo_datain | data[i*WIDTH +: WIDTH];
    end

    // Reset gates the handshake combinationally so no word is taken in the reset cycle.
    always_comb begin
        ack = '0;
        if (state == BURST && req[gidx] && !fifo_full && !reset)
            ack[gidx] = 1'b1;
    end

    assign fifo_write = |ack;
    assign busy       = (state == BURST);

    assign done = (state == BURST) &&
                  (!req[gidx] ||
                   (fifo_write && (last[gidx] || beats == CW'(MAXBURST - 1))));

    always_comb begin
        state_next = state;
        grant_next = grant;
        rr_next    = rr_ptr;
        beats_next = beats;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_next = BURST;
                    grant_next = NREQ'(1) << pick;
                    beats_next = '0;
                end
            end
            BURST: begin
                if (fifo_write && beats != CW'(MAXBURST))
                    beats_next = beats + CW'(1);
                if (done) begin
                    state_next = IDLE;
                    grant_next = '0;
                    rr_next    = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            beats  <= '0;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            rr_ptr <= rr_next;
            beats  <= beats_next;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: default instance plus a MAXBURST=2 instance for rotation.
module tb_fifo_write_arbiter;
    localparam int NREQ = 4;
    localparam int WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req, last;
    logic [NREQ*WIDTH-1:0] data;
    logic                  fifo_full;
    logic [NREQ-1:0]       ack, grant, ack2, grant2;
    logic [WIDTH-1:0]      fifo_datain, fifo_datain2;
    logic                  fifo_write, busy, fifo_write2, busy2;

    int checks = 0;
    int errors = 0;
    int pidx [NREQ];

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXBURST(8)) dut (
        .clk(clk), .reset(reset), .req(req), .last(last), .data(data), .ack(ack),
        .fifo_full(fifo_full), .fifo_datain(fifo_datain), .fifo_write(fifo_write),
        .grant(grant), .busy(busy)
    );

    fifo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXBURST(2)) dut2 (
        .clk(clk), .reset(reset), .req(req), .last(last), .data(data), .ack(ack2),
        .fifo_full(fifo_full), .fifo_datain(fifo_datain2), .fifo_write(fifo_write2),
        .grant(grant2), .busy(busy2)
    );

    // Producers present word {port, index} and advance when acked by the main instance.
    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++)
            if (reset) pidx[i] <= 0;
            else if (ack[i]) pidx[i] <= pidx[i] + 1;
    end
    always_comb begin
        for (int i = 0; i < NREQ; i++)
            data[i*WIDTH +: WIDTH] = {8'(i), 24'(pidx[i])};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change just after the edge, checks 2ns later.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; last = '0; fifo_full = 1'b0;
        nxt(); nxt();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = '0; last = '0; fifo_full = 1'b0;
        nxt(); nxt();

        // Reset state and gating while reset is held with requests present.
        req = 4'b0101;
        settle();
        chk("rst_ack", ack, 0);
        chk("rst_write", fifo_write, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);

        // Port 0 then port 2: 8-word max burst, idle cycle, then rotation.
        nxt(); reset = 1'b0; settle();
        chk("idle_ack", ack, 0);
        chk("idle_write", fifo_write, 0);
        for (int k = 0; k < 8; k++) begin
            nxt(); settle();
            chk("b0_grant", grant, 4'b0001);
            chk("b0_ack", ack, 4'b0001);
            chk("b0_data", fifo_datain, 32'h0000_0000 + k);
        end
        nxt(); settle();
        chk("b0_end_grant", grant, 0);
        chk("b0_end_busy", busy, 0);
        chk("b0_end_ack", ack, 0);
        nxt(); settle();
        chk("b1_grant", grant, 4'b0100);
        chk("b1_ack", ack, 4'b0100);
        req = '0;
        nxt(); settle();

        // Port 2 burst of 3 ending on last; next winner must be port 3.
        do_reset();
        req = 4'b0100;
        settle();
        for (int k = 0; k < 3; k++) begin
            nxt();
            last = (k == 2) ? 4'b0100 : 4'b0000;
            settle();
            chk("p2_write", fifo_write, 1);
            chk("p2_data", fifo_datain, 32'h0200_0000 + k);
        end
        nxt(); req = 4'b1111; last = '0; settle();
        chk("p2_busy_fall", busy, 0);
        chk("p2_no_write", fifo_write, 0);
        nxt(); settle();
        chk("p2_rr_next", grant, 4'b1000);
        req = '0;
        nxt();

        // Continuous requests on the 2-beat instance rotate through every port.
        do_reset();
        req = 4'b1111;
        settle();
        for (int p = 0; p < 5; p++) begin
            nxt(); settle();
            chk("rot_grant", grant2, 4'b0001 << (p % 4));
            chk("rot_ack1", ack2, 4'b0001 << (p % 4));
            nxt(); settle();
            chk("rot_ack2", ack2, 4'b0001 << (p % 4));
            nxt(); settle();
            chk("rot_gap", grant2, 0);
        end
        req = '0;

        // fifo_full stall mid-burst holds everything, burst still totals 8 words.
        do_reset();
        req = 4'b0001;
        settle();
        for (int k = 0; k < 3; k++) begin
            nxt(); settle();
            chk("st_pre_data", fifo_datain, 32'h0000_0000 + k);
            chk("st_pre_ack", ack, 4'b0001);
        end
        for (int k = 0; k < 5; k++) begin
            nxt(); fifo_full = 1'b1; settle();
            chk("st_ack", ack, 0);
            chk("st_write", fifo_write, 0);
            chk("st_grant", grant, 4'b0001);
            chk("st_busy", busy, 1);
        end
        for (int k = 3; k < 8; k++) begin
            nxt(); fifo_full = 1'b0; settle();
            chk("st_post_ack", ack, 4'b0001);
            chk("st_post_data", fifo_datain, 32'h0000_0000 + k);
        end
        nxt(); settle();
        chk("st_end_busy", busy, 0);
        req = '0;

        // Reset on the 4th word: no ack that cycle, restart favours port 0.
        do_reset();
        req = 4'b0011;
        settle();
        for (int k = 0; k < 3; k++) begin
            nxt(); settle();
            chk("rb_ack", ack, 4'b0001);
        end
        nxt(); reset = 1'b1; settle();
        chk("rb_ack_rst", ack, 0);
        chk("rb_write_rst", fifo_write, 0);
        nxt(); reset = 1'b0; settle();
        chk("rb_grant_clr", grant, 0);
        nxt(); settle();
        chk("rb_regrant", grant, 4'b0001);
        req = '0;
        nxt();

        // Owner drops req after 2 words; next requester takes over, data in order.
        do_reset();
        req = 4'b0110;
        settle();
        for (int k = 0; k < 2; k++) begin
            nxt(); settle();
            chk("dr_grant", grant, 4'b0010);
            chk("dr_data", fifo_datain, 32'h0100_0000 + k);
            chk("dr_write", fifo_write, 1);
        end
        nxt(); req = 4'b0100; settle();
        chk("dr_drop_ack", ack, 0);
        nxt(); settle();
        chk("dr_idle", grant, 0);
        nxt(); settle();
        chk("dr_next_grant", grant, 4'b0100);
        chk("dr_next_data", fifo_datain, 32'h0200_0000);
        chk("dr_next_ack", ack, 4'b0100);
        req = '0;
        nxt(); nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
